uart_rx_core: RTL and testbench
===============================

// Module: uart_rx_core
// PURPOSE
//  Receive half of the UART link: 8N1 asynchronous receiver, 1 Mbaud at 100 MHz by default.
//  Synchronises the serial line and validates the start bit at mid-bit.
//  Samples 8 data bits LSB-first and checks the stop bit.
//  Presents each byte through a one-entry holding register with a valid/ack handshake.
//  Sits beside the UART transmitter inside the tt_um top; serial input comes from a ui_in pin.
// PARAMETERS
//  CLKS_PER_BIT  100  clk cycles per bit period (100 MHz / 1 Mbaud); must be >= 8
// PORTS
//  clk        in   1  system clock, single clock domain
//  rst_n      in   1  asynchronous, active-low reset
//  ena        in   1  block enable; 0 forces FSM to IDLE, holding register retained
//  rx         in   1  serial line, idle high, asynchronous to clk
//  rx_ack     in   1  consumer pops holding register (1-cycle pulse)
//  rx_data    out  8  received byte, stable while rx_valid=1
//  rx_valid   out  1  holding register full
//  frame_err  out  1  1-cycle pulse: stop bit sampled 0
//  overrun    out  1  sticky: byte completed while rx_valid=1
//  busy       out  1  FSM not in IDLE
// BEHAVIOUR
//  Reset values:
//   - rx_data=0x00, rx_valid=0, frame_err=0, overrun=0, busy=0
//   - sync flops=0, line_armed=0, FSM=IDLE
//  Synchroniser: 2 flops; rx_s lags rx by 2 clk.
//  line_armed: set when rx_s=1 in IDLE; cleared on start detect.
//   - A line held low through reset is never taken as a start.
//  Bit counter: width $clog2(CLKS_PER_BIT), cleared on every state change.
//  Bit index: 3 bits.
//  FSM states and transitions:
//   - IDLE: rx_s=0 && line_armed && ena -> START, counter=0.
//   - START: at counter=CLKS_PER_BIT/2-1, sample rx_s.
//     - 1 -> IDLE (glitch rejected, no flags).
//     - 0 -> DATA, counter=0, idx=0.
//   - DATA: every CLKS_PER_BIT cycles, sample rx_s into shift[idx], LSB first.
//     - After idx=7 -> STOP.
//   - STOP: after CLKS_PER_BIT cycles, sample rx_s.
//     - 1 -> deliver byte.
//     - 0 -> frame_err=1 for one cycle, byte discarded.
//     - Both cases -> IDLE; re-arm needs rx_s=1, so a break does not retrigger.
//  Latency: rx_valid rises 2 + CLKS_PER_BIT/2 + 9*CLKS_PER_BIT + 1 clk after the rx falling edge.
//   - CLKS_PER_BIT=100: 953 clk.
//  Deliver rules:
//   - rx_valid=0: load rx_data, set rx_valid.
//   - rx_valid=1 with no rx_ack that cycle: new byte dropped, old byte kept, overrun=1.
//   - rx_ack coincident with deliver: new byte loaded, rx_valid stays 1, no overrun.
//  rx_ack: with rx_valid=1 -> rx_valid=0 next cycle, overrun cleared; with rx_valid=0 it is ignored.
//  ena deasserted mid-frame: FSM -> IDLE, partial byte lost, no flags.
//  rst_n asserted mid-frame: immediate clear of all state; frame lost.
// STRUCTURE
//  uart_pkg, shared with the transmitter:
//   - state enum {IDLE, START, DATA, STOP}
//   - DATA_BITS=8, default CLKS_PER_BIT=100
//  Sub-module: uart_rx_sync (2-flop synchroniser, reset value 0).
//  Remainder is one FSM plus counters in this file.
// TESTING
//  1. 0x55 framed 8N1 at 100 clk/bit -> rx_valid at edge+953 clk, rx_data=0x55, frame_err=0.
//  2. 0xA5 then 0x3C back-to-back, rx_ack after each -> rx_data 0xA5 then 0x3C, overrun=0.
//  3. rx low for 30 clk then high -> no rx_valid, busy returns to 0 within 52 clk.
//  4. 0xFF with stop bit driven 0 -> frame_err one-cycle pulse, rx_valid stays 0.
//     Then rx high plus a new 0x12 frame -> received correctly.
//  5. 0x11 then 0x22 with no rx_ack -> rx_data=0x11, overrun=1.
//     rx_ack -> rx_valid=0, overrun=0.
//  6. rst_n low during DATA bit 4 -> all outputs 0.
//     Next 0x81 frame after line idle -> rx_data=0x81.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding and frame geometry.
package uart_pkg;

  localparam int unsigned DataBits          = 8;
  localparam int unsigned DefaultClksPerBit = 100;

  typedef enum logic [1:0] {
    StIdle,
    StStart,
    StData,
    StStop
  } uart_state_e;

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchroniser for the asynchronous serial input; resets to 0.
module uart_rx_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/uart_rx_core.sv
// 8N1 UART receiver: mid-bit sampling FSM feeding a one-entry holding register
// with a valid/ack handshake, frame-error pulse and sticky overrun flag.
module uart_rx_core
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = DefaultClksPerBit
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic       rx,
  input  logic       rx_ack,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       frame_err,
  output logic       overrun,
  output logic       busy
);

  localparam int unsigned CntW = $clog2(CLKS_PER_BIT);
  localparam logic [CntW-1:0] HalfMax = CntW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CntW-1:0] BitMax  = CntW'(CLKS_PER_BIT - 1);

  logic rx_s;

  uart_rx_sync u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (rx),
    .q     (rx_s)
  );

  uart_state_e         state_q, state_d;
  logic [CntW-1:0]     cnt_q, cnt_d;
  logic [2:0]          idx_q, idx_d;
  logic [DataBits-1:0] shift_q, shift_d;
  logic                armed_q, armed_d;
  logic [7:0]          data_q, data_d;
  logic                valid_q, valid_d;
  logic                ferr_q, ferr_d;
  logic                ovr_q, ovr_d;
  logic                deliver;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      armed_q <= 1'b0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      armed_q <= armed_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
      ovr_q   <= ovr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + CntW'(1);
    idx_d   = idx_q;
    shift_d = shift_q;
    armed_d = armed_q;
    ferr_d  = 1'b0;
    deliver = 1'b0;

    unique case (state_q)
      StIdle: begin
        cnt_d = '0;
        // Arming requires a high line, so a line held low (reset, break) never starts a frame.
        if (rx_s) armed_d = 1'b1;
        if (!rx_s && armed_q && ena) begin
          state_d = StStart;
          armed_d = 1'b0;
        end
      end
      StStart: begin
        if (cnt_q == HalfMax) begin
          cnt_d = '0;
          if (rx_s) begin
            state_d = StIdle;
          end else begin
            state_d = StData;
            idx_d   = '0;
          end
        end
      end
      StData: begin
        if (cnt_q == BitMax) begin
          cnt_d          = '0;
          shift_d[idx_q] = rx_s;
          idx_d          = idx_q + 3'd1;
          if (idx_q == 3'd7) state_d = StStop;
        end
      end
      StStop: begin
        if (cnt_q == BitMax) begin
          cnt_d   = '0;
          state_d = StIdle;
          if (rx_s) deliver = 1'b1;
          else      ferr_d  = 1'b1;
        end
      end
      default: begin
        state_d = StIdle;
        cnt_d   = '0;
      end
    endcase

    if (!ena) begin
      state_d = StIdle;
      cnt_d   = '0;
      deliver = 1'b0;
      ferr_d  = 1'b0;
    end
  end

  // Holding register: an ack in the same cycle as a delivery frees the slot for the new byte.
  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    ovr_d   = ovr_q;
    if (rx_ack && valid_q) begin
      valid_d = 1'b0;
      ovr_d   = 1'b0;
    end
    if (deliver) begin
      if (!valid_q || rx_ack) begin
        data_d  = shift_q;
        valid_d = 1'b1;
      end else begin
        ovr_d = 1'b1;
      end
    end
  end

  assign rx_data   = data_q;
  assign rx_valid  = valid_q;
  assign frame_err = ferr_q;
  assign overrun   = ovr_q;
  assign busy      = (state_q != StIdle);

endmodule

// File: tb/tb_uart_rx_core.sv
// Self-checking bench for uart_rx_core: directed scenarios plus random frames
// checked against a frame-level model of the holding register and flags.
module tb_uart_rx_core;

  localparam int unsigned C   = 100;
  localparam int unsigned LAT = 2 + C / 2 + 9 * C + 1;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ena = 1'b1;
  logic       rx = 1'b1;
  logic       rx_ack = 1'b0;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       frame_err;
  logic       overrun;
  logic       busy;

  uart_rx_core #(.CLKS_PER_BIT(C)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .ena       (ena),
    .rx        (rx),
    .rx_ack    (rx_ack),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .frame_err (frame_err),
    .overrun   (overrun),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Event monitor, sampled on the falling edge.
  int unsigned rise_cyc = 0;
  int unsigned fe_cnt = 0;
  int unsigned fe_long = 0;
  logic        prev_valid = 1'b0;
  logic        prev_fe = 1'b0;
  always @(negedge clk) begin
    if (rx_valid && !prev_valid) rise_cyc = cyc;
    if (frame_err) fe_cnt++;
    if (frame_err && prev_fe) fe_long++;
    prev_valid = rx_valid;
    prev_fe    = frame_err;
  end

  int unsigned vectors = 0;
  int unsigned miscompares = 0;
  int unsigned start_cyc = 0;
  int unsigned exp_fe = 0;
  logic [7:0]  m_data = 8'h00;
  logic        m_valid = 1'b0;
  logic        m_ovr = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic idle(input int unsigned n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Drives a full 8N1 frame; optionally pulses rx_ack on the delivery edge.
  task automatic send_frame(input logic [7:0] b, input logic stop, input bit ack_dlv);
    start_cyc = cyc;
    fork
      begin
        rx = 1'b0;
        idle(C);
        for (int i = 0; i < 8; i++) begin
          rx = b[i];
          idle(C);
        end
        rx = stop;
        idle(C);
        rx = 1'b1;
      end
      begin
        if (ack_dlv) begin
          idle(LAT - 1);
          rx_ack = 1'b1;
          idle(1);
          rx_ack = 1'b0;
        end
      end
    join
    if (!stop) exp_fe++;
    else if (!m_valid || ack_dlv) begin
      m_data  = b;
      m_valid = 1'b1;
      m_ovr   = 1'b0;
    end else m_ovr = 1'b1;
  endtask

  task automatic ack();
    rx_ack = 1'b1;
    idle(1);
    rx_ack = 1'b0;
    if (m_valid) begin
      m_valid = 1'b0;
      m_ovr   = 1'b0;
    end
  endtask

  task automatic check_state(input string tag);
    check({tag, ".valid"}, rx_valid, m_valid);
    check({tag, ".data"}, rx_data, m_data);
    check({tag, ".overrun"}, overrun, m_ovr);
    check({tag, ".busy"}, busy, 1'b0);
    check({tag, ".frame_errs"}, fe_cnt, exp_fe);
    check({tag, ".fe_width"}, fe_long, 0);
  endtask

  initial begin
    logic [7:0] rb;
    logic       rs;
    bit         seen;

    // Reset values
    idle(3);
    check("rst.data", rx_data, 8'h00);
    check("rst.valid", rx_valid, 1'b0);
    check("rst.ferr", frame_err, 1'b0);
    check("rst.overrun", overrun, 1'b0);
    check("rst.busy", busy, 1'b0);
    rst_n = 1'b1;
    idle(20);

    // 1: single byte, exact latency
    send_frame(8'h55, 1'b1, 1'b0);
    check("t1.latency", rise_cyc - start_cyc, LAT);
    check_state("t1");

    // 2: back-to-back bytes with ack after each
    ack();
    send_frame(8'hA5, 1'b1, 1'b0);
    check_state("t2a");
    ack();
    send_frame(8'h3C, 1'b1, 1'b0);
    check_state("t2b");
    ack();
    check_state("t2c");

    // 3: short glitch is rejected
    rx = 1'b0;
    idle(10);
    check("t3.busy_hi", busy, 1'b1);
    idle(20);
    rx = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 52 && !seen; i++) begin
      idle(1);
      if (!busy) seen = 1'b1;
    end
    check("t3.busy_back", seen, 1'b1);
    idle(2 * C);
    check_state("t3");

    // 4: framing error then a clean frame
    send_frame(8'hFF, 1'b0, 1'b0);
    check_state("t4a");
    idle(20);
    send_frame(8'h12, 1'b1, 1'b0);
    check_state("t4b");
    ack();

    // 5: overrun, then ack clears it
    send_frame(8'h11, 1'b1, 1'b0);
    send_frame(8'h22, 1'b1, 1'b0);
    check_state("t5a");
    ack();
    check_state("t5b");

    // Ack coincident with delivery: new byte taken, no overrun
    send_frame(8'h33, 1'b1, 1'b0);
    send_frame(8'h44, 1'b1, 1'b1);
    check_state("coinc");
    send_frame(8'h5A, 1'b1, 1'b0);
    check_state("coinc_ovr");

    // ena dropped mid-frame: back to idle, nothing else disturbed
    rx = 1'b0;
    idle(3 * C);
    ena = 1'b0;
    idle(1);
    check("ena.busy", busy, 1'b0);
    rx = 1'b1;
    idle(2 * C);
    ena = 1'b1;
    idle(2 * C);
    check_state("ena");

    // 6: reset during data bit 4, line held low through reset
    rx = 1'b0;
    idle(C);
    for (int i = 0; i < 4; i++) begin
      rx = i[0];
      idle(C);
    end
    rx = 1'b0;
    idle(C / 2);
    rst_n = 1'b0;
    #2;
    check("t6.data", rx_data, 8'h00);
    check("t6.valid", rx_valid, 1'b0);
    check("t6.ferr", frame_err, 1'b0);
    check("t6.overrun", overrun, 1'b0);
    check("t6.busy", busy, 1'b0);
    m_data  = 8'h00;
    m_valid = 1'b0;
    m_ovr   = 1'b0;
    idle(5);
    rst_n = 1'b1;
    idle(3 * C);
    check_state("t6.low_line");
    rx = 1'b1;
    idle(2 * C);
    send_frame(8'h81, 1'b1, 1'b0);
    check_state("t6.next");

    // Random frames
    for (int n = 0; n < 10; n++) begin
      rb = 8'($urandom);
      rs = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 1) == 1) ack();
      idle($urandom_range(1, 50));
      send_frame(rb, rs, ($urandom_range(0, 3) == 0));
      check_state($sformatf("rand%0d", n));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
